// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a simple single-bus CPU datapath. A state register
// (IDLE, T0..T7, HALT) steps through the instruction fetch and then an
// opcode-specific execute sequence. Every output is a pure combinational decode
// of (state, opcode, CON_FF). mem_ready only affects which state comes next, so
// a memory wait never glitches the strobes.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset_n    in   asynchronous active-low reset, forces IDLE
//   IR_data    in   instruction register contents, opcode = IR_data[31:27]
//   mem_ready  in   memory completion, ends Read/Write wait states
//   CON_FF     in   branch condition from the datapath
//   PCout .. CONin  datapath strobes
//   Gra, Grb, Grc, Rin, Rout, BAout  register-select controls
//   alu_op     out  5-bit ALU operation (non-zero only in T4/T5)
//   run        out  1 while in T0..T7
//   illegal    out  one-cycle pulse in T3 for an unsupported opcode
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IR_data,
    input  logic        mem_ready,
    input  logic        CON_FF,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state_q, state_d;
    logic [4:0] opcode;

    // Only the opcode field is decoded; the operand fields feed the datapath.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR_data[26:0];

    assign opcode = IR_data[31:27];

    // Instruction classes
    logic is_alu, is_imm, is_ld, is_st, is_br, is_nop, is_halt, is_legal;
    always_comb begin
        is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
        is_imm   = (opcode == OP_ADDI) || (opcode == OP_LDI);
        is_ld    = (opcode == OP_LD);
        is_st    = (opcode == OP_ST);
        is_br    = (opcode == OP_BR);
        is_nop   = (opcode == OP_NOP);
        is_halt  = (opcode == OP_HALT);
        is_legal = is_alu || is_imm || is_ld || is_st || is_br || is_nop || is_halt;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_ready ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_alu || is_imm || is_ld || is_st || is_br) begin
                    state_d = S_T4;
                end else begin
                    // nop and unsupported opcodes both finish here
                    state_d = S_T0;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6: begin
                if (is_ld) begin
                    state_d = mem_ready ? S_T7 : S_T6;
                end else if (is_st) begin
                    state_d = S_T7;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T7: begin
                if (is_st) begin
                    state_d = mem_ready ? S_T0 : S_T7;
                end else begin
                    state_d = S_T0;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: all strobes default low, each state raises only its own.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        CONin   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        alu_op  = 5'b00000;
        run     = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            S_T0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_imm || is_ld || is_st) begin
                    // addi reads rb as a register; ldi/ld/st use base-address
                    // semantics so r0 reads as zero.
                    Grb   = 1'b1;
                    Yin   = 1'b1;
                    Rout  = (opcode == OP_ADDI);
                    BAout = (opcode != OP_ADDI);
                end else if (is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_alu) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else if (is_imm || is_ld || is_st) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = OP_ADD;
                end else if (is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_alu || is_imm) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (is_br) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = OP_ADD;
                end
            end
            S_T6: begin
                run = 1'b1;
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1;
                    PCin    = CON_FF;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
                // IDLE and HALT: everything stays low
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Each instruction is expanded into a list of per-cycle steps (expected output
// word plus the mem_ready value to drive for that cycle) pushed onto a
// scoreboard queue. The drain task pops one step per clock, compares the DUT
// outputs on the falling edge, then drives the inputs for the next rising edge.
// The execute phases come from a vector table. Memory waits, halt, and reset
// in the middle of a wait are written out by hand.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] IR_data;
    logic        mem_ready;
    logic        CON_FF;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
    logic Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
    logic [4:0] alu_op;

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .IR_data(IR_data), .mem_ready(mem_ready),
        .CON_FF(CON_FF), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word
    logic [26:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
                  Yin, Zin, Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout,
                  alu_op, run, illegal};

    localparam logic [26:0] B_PCOUT = 27'd1 << 26;
    localparam logic [26:0] B_PCIN  = 27'd1 << 25;
    localparam logic [26:0] B_INCPC = 27'd1 << 24;
    localparam logic [26:0] B_MARIN = 27'd1 << 23;
    localparam logic [26:0] B_MDRIN = 27'd1 << 22;
    localparam logic [26:0] B_MDROU = 27'd1 << 21;
    localparam logic [26:0] B_READ  = 27'd1 << 20;
    localparam logic [26:0] B_WRITE = 27'd1 << 19;
    localparam logic [26:0] B_IRIN  = 27'd1 << 18;
    localparam logic [26:0] B_YIN   = 27'd1 << 17;
    localparam logic [26:0] B_ZIN   = 27'd1 << 16;
    localparam logic [26:0] B_ZLO   = 27'd1 << 15;
    localparam logic [26:0] B_COUT  = 27'd1 << 14;
    localparam logic [26:0] B_CONIN = 27'd1 << 13;
    localparam logic [26:0] B_GRA   = 27'd1 << 12;
    localparam logic [26:0] B_GRB   = 27'd1 << 11;
    localparam logic [26:0] B_GRC   = 27'd1 << 10;
    localparam logic [26:0] B_RIN   = 27'd1 << 9;
    localparam logic [26:0] B_ROUT  = 27'd1 << 8;
    localparam logic [26:0] B_BAOUT = 27'd1 << 7;
    localparam logic [26:0] B_RUN   = 27'd1 << 1;
    localparam logic [26:0] B_ILL   = 27'd1 << 0;

    function automatic logic [26:0] alu(input logic [4:0] op);
        return {20'd0, op, 2'b00};
    endfunction

    // Fetch words
    localparam logic [26:0] W_F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [26:0] W_F1 = B_RUN | B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [26:0] W_F2 = B_RUN | B_MDROU | B_IRIN;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        mr;
        logic [26:0] exp;
    } step_t;

    typedef struct {
        logic [4:0]       op;
        logic             con;
        int               n;
        logic [4:0][26:0] w;
    } vec_t;

    step_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          stepno = 0;
    logic [31:0] cur_ir;
    logic        cur_con;

    function automatic vec_t mkv(input logic [4:0] op, input logic con, input int n,
                                 input logic [26:0] a, input logic [26:0] b,
                                 input logic [26:0] c, input logic [26:0] d,
                                 input logic [26:0] e);
        vec_t v;
        v.op = op; v.con = con; v.n = n;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
        return v;
    endfunction

    task automatic push(input logic [26:0] exp, input logic mr);
        step_t s;
        s.ir = cur_ir; s.con = cur_con; s.mr = mr; s.exp = exp;
        sb.push_back(s);
    endtask

    task automatic set_instr(input logic [4:0] op, input logic con);
        cur_ir  = {op, 27'h5A3C_0F1 ^ 27'($urandom)};
        cur_con = con;
    endtask

    // Fetch with `waits` cycles of mem_ready low during T1
    task automatic push_fetch(input int waits);
        push(W_F0, 1'b1);
        for (int i = 0; i < waits; i++) push(W_F1, 1'b0);
        push(W_F1, 1'b1);
        push(W_F2, 1'b1);
    endtask

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, stepno, got, want);
        end
    endtask

    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            stepno++;
            check("outputs", obs, s.exp);
            total++;
            if (Read && Write) begin
                bad++;
                $display("FAIL read_write_overlap step=%0d got=11 want=not both", stepno);
            end
            $display("step %0d ir_op=%b obs=%h exp=%h", stepno, s.ir[31:27], obs, s.exp);
            // Drive the inputs that decide the next transition
            IR_data   = s.ir;
            CON_FF    = s.con;
            mem_ready = s.mr;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", obs, 27'd0);
        reset_n = 1'b1;               // released at negedge: still IDLE now
        #1;
        check("idle_after_release", obs, 27'd0);
    endtask

    vec_t tbl[13];

    initial begin
        logic [26:0] m3, m4;
        reset_n   = 1'b0;
        IR_data   = 32'd0;
        mem_ready = 1'b1;
        CON_FF    = 1'b0;
        cur_ir    = 32'd0;
        cur_con   = 1'b0;

        m3 = B_RUN | B_GRB | B_BAOUT | B_YIN;          // ldi/ld/st T3
        m4 = B_RUN | B_COUT | B_ZIN | alu(5'b00011);   // immediate-add T4
        tbl[0]  = mkv(5'b00011, 0, 3, B_RUN|B_GRB|B_ROUT|B_YIN, B_RUN|B_GRC|B_ROUT|B_ZIN|alu(5'b00011), B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[1]  = mkv(5'b00100, 0, 3, B_RUN|B_GRB|B_ROUT|B_YIN, B_RUN|B_GRC|B_ROUT|B_ZIN|alu(5'b00100), B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[2]  = mkv(5'b00101, 1, 3, B_RUN|B_GRB|B_ROUT|B_YIN, B_RUN|B_GRC|B_ROUT|B_ZIN|alu(5'b00101), B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[3]  = mkv(5'b00110, 0, 3, B_RUN|B_GRB|B_ROUT|B_YIN, B_RUN|B_GRC|B_ROUT|B_ZIN|alu(5'b00110), B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[4]  = mkv(5'b01100, 0, 3, B_RUN|B_GRB|B_ROUT|B_YIN, m4, B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[5]  = mkv(5'b00001, 1, 3, m3, m4, B_RUN|B_ZLO|B_GRA|B_RIN, 0, 0);
        tbl[6]  = mkv(5'b00000, 0, 5, m3, m4, B_RUN|B_ZLO|B_MARIN, B_RUN|B_READ|B_MDRIN, B_RUN|B_MDROU|B_GRA|B_RIN);
        tbl[7]  = mkv(5'b00010, 0, 5, m3, m4, B_RUN|B_ZLO|B_MARIN, B_RUN|B_GRA|B_ROUT|B_MDRIN, B_RUN|B_WRITE);
        tbl[8]  = mkv(5'b10010, 0, 4, B_RUN|B_GRA|B_ROUT|B_CONIN, B_RUN|B_PCOUT|B_YIN, m4, B_RUN|B_ZLO, 0);
        tbl[9]  = mkv(5'b10010, 1, 4, B_RUN|B_GRA|B_ROUT|B_CONIN, B_RUN|B_PCOUT|B_YIN, m4, B_RUN|B_ZLO|B_PCIN, 0);
        tbl[10] = mkv(5'b11010, 1, 1, B_RUN, 0, 0, 0, 0);
        tbl[11] = mkv(5'b11111, 0, 1, B_RUN|B_ILL, 0, 0, 0, 0);
        tbl[12] = mkv(5'b01000, 0, 1, B_RUN|B_ILL, 0, 0, 0, 0);

        do_reset();

        // Table-driven execute sequences, all with mem_ready high
        for (int t = 0; t < 13; t++) begin
            set_instr(tbl[t].op, tbl[t].con);
            push_fetch(0);
            for (int k = 0; k < tbl[t].n; k++) push(tbl[t].w[k], 1'b1);
        end

        // add with a 3-cycle memory wait in fetch: T1 held 4 cycles
        set_instr(5'b00011, 1'b0);
        push_fetch(3);
        push(B_RUN|B_GRB|B_ROUT|B_YIN, 1'b1);
        push(B_RUN|B_GRC|B_ROUT|B_ZIN|alu(5'b00011), 1'b1);
        push(B_RUN|B_ZLO|B_GRA|B_RIN, 1'b1);

        // st with mem_ready low for 2 cycles in T7: Write for 3 cycles
        set_instr(5'b00010, 1'b0);
        push_fetch(0);
        push(m3, 1'b1);
        push(m4, 1'b1);
        push(B_RUN|B_ZLO|B_MARIN, 1'b1);
        push(B_RUN|B_GRA|B_ROUT|B_MDRIN, 1'b1);
        push(B_RUN|B_WRITE, 1'b0);
        push(B_RUN|B_WRITE, 1'b0);
        push(B_RUN|B_WRITE, 1'b1);

        // ld whose T6 wait is cut short by reset
        set_instr(5'b00000, 1'b0);
        push(W_F0, 1'b1);      // the st above must return to T0
        push(W_F1, 1'b1);
        push(W_F2, 1'b1);
        push(m3, 1'b1);
        push(m4, 1'b1);
        push(B_RUN|B_ZLO|B_MARIN, 1'b1);
        push(B_RUN|B_READ|B_MDRIN, 1'b0);
        push(B_RUN|B_READ|B_MDRIN, 1'b0);
        drain();

        // Still waiting in T6; assert reset mid-cycle
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_in_ld_wait", obs, 27'd0);
        do_reset();
        push(W_F0, 1'b1);      // IDLE for one edge, then T0

        // halt: run drops after T3 and stays low
        set_instr(5'b11011, 1'b0);
        push(W_F1, 1'b1);
        push(W_F2, 1'b1);
        push(B_RUN, 1'b1);
        for (int i = 0; i < 20; i++) push(27'd0, 1'b1);
        drain();

        // Only reset leaves HALT
        do_reset();
        set_instr(5'b11010, 1'b0);
        push(W_F0, 1'b1);
        push(W_F1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
